// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM state encoding and the baud divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Wide enough to index up to 9 data bits or 2 stop bits.
    localparam int BIT_IDX_W = 4;

    function automatic int baud_div(input longint clk_freq, input longint baud_rate);
        return int'(clk_freq / baud_rate);
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmitter: enqueue strobe/data plus FIFO and FSM status.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    logic [DATA_BITS-1:0]          wr_data;
    logic                          wr_en;
    logic                          full;
    logic                          empty;
    logic [$clog2(FIFO_DEPTH):0]   level;
    logic                          overflow;
    logic                          busy;

    modport master (
        output wr_data, wr_en,
        input  full, empty, level, overflow, busy
    );

    modport slave (
        input  wr_data, wr_en,
        output full, empty, level, overflow, busy
    );
endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with registered full/empty/level and a one-cycle overflow pulse.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two >= 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full_q, full_d, empty_q, empty_d, overflow_q, overflow_d;
    logic             wr_ok, rd_ok;

    // Full is judged on the registered flag, so a pop in the same cycle cannot rescue a write.
    assign wr_ok = wr_en && !full_q;
    assign rd_ok = rd_en && !empty_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        full_d     = (level_d == (AW+1)'(DEPTH));
        empty_d    = (level_d == '0);
        overflow_d = wr_en && full_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    // Head word is read combinationally so the FSM can pop it in the same cycle it sees !empty.
    assign rd_data  = mem_q[rd_ptr_q];
    assign full     = full_q;
    assign empty    = empty_q;
    assign level    = level_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a write FIFO; frames are sent LSB-first with no gap between queued words.
// Optional parity bit enabled by defining UART_TX_PARITY_EN (adds parameter PARITY_ODD).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 115200,
    parameter int DATA_BITS      = 8,
    parameter int STOP_BITS      = 1,
    parameter int FIFO_DEPTH     = 16
`ifdef UART_TX_PARITY_EN
    , parameter bit PARITY_ODD   = 1'b0
`endif
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_fifo_if.slave bus,
    output logic          uart_txd
);
    localparam int DIV   = baud_div(clk_freq, uart_baud_rate);
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [BIT_IDX_W-1:0] DATA_LAST = BIT_IDX_W'(DATA_BITS - 1);
    localparam logic [BIT_IDX_W-1:0] STOP_LAST = BIT_IDX_W'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_tx_fifo: clk_freq / uart_baud_rate must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end

    tx_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   txd_q, txd_d;
    logic [DATA_BITS-1:0]   fifo_rd_data;
    logic                   pop, bit_done;
`ifdef UART_TX_PARITY_EN
    logic                   parity_q, parity_d;
`endif

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_en),
        .wr_data  (bus.wr_data),
        .rd_en    (pop),
        .rd_data  (fifo_rd_data),
        .full     (bus.full),
        .empty    (bus.empty),
        .level    (bus.level),
        .overflow (bus.overflow)
    );

    assign bit_done = (cnt_q == CNT_LAST);
    assign bus.busy = (state_q != ST_IDLE);
    assign uart_txd = txd_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!bus.empty) pop = 1'b1;
            end
            ST_START: begin
                if (bit_done) begin
                    state_d   = ST_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == DATA_LAST) begin
                        bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = ST_PARITY;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (bit_idx_q == STOP_LAST) begin
                        bit_idx_d = '0;
                        if (!bus.empty) pop = 1'b1;
                        else            state_d = ST_IDLE;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A pop from IDLE or from the last stop bit both load the next word and start a frame.
        if (pop) begin
            shift_d   = fifo_rd_data;
            state_d   = ST_START;
            cnt_d     = '0;
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            parity_d  = (^fifo_rd_data) ^ PARITY_ODD;
`endif
        end
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = parity_q;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised UART transmitter with an internal write FIFO, for the system's UART path.
- Replaces the fixed 8N1 single-byte transmitter.
- Configurable data width, stop bits and FIFO depth; the baud divisor is derived from clk_freq / uart_baud_rate.
- Software or bus logic pushes words back-to-back. The block serialises them LSB-first on uart_txd, with no idle gap between queued frames.

Parameters:
- clk_freq, 50000000, system clock frequency in Hz.
- uart_baud_rate, 115200, line rate in bit/s. DIV = clk_freq / uart_baud_rate, truncated; DIV >= 2 is required, otherwise elaboration error.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_data  in  DATA_BITS  word to enqueue.
- wr_en  in  1  enqueue strobe, sampled on rising edge.
- full  out  1  FIFO holds FIFO_DEPTH entries.
- empty  out  1  FIFO holds 0 entries.
- level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  one-cycle pulse when a write is dropped.
- busy  out  1  FSM not in IDLE.
- uart_txd  out  1  serial output, idle high, registered.

Behaviour:
- Reset values (synchronous, rst high at an edge): uart_txd=1, busy=0, full=0, empty=1, level=0, overflow=0, FSM=IDLE, pointers=0, baud counter=0.
- Reset mid-frame aborts the frame. uart_txd=1 after that edge, and all FIFO contents are discarded.
- FIFO:
  - A write with wr_en=1 and full=0 stores wr_data at the write pointer; level increments.
  - A write with full=1 is dropped and overflow=1 for the next cycle only. This holds even if a pop happens in the same cycle, because full is evaluated before the pop.
  - A simultaneous accepted write and pop leaves level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - full/empty/level are registered and consistent with each other every cycle.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
  - IDLE: uart_txd=1. If empty=0, pop the head into the shift register and go to START.
  - START: uart_txd=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: uart_txd=shift[0] for DIV cycles, then shift right. After DATA_BITS bits, go to PARITY or STOP.
  - STOP: uart_txd=1 for STOP_BITS*DIV cycles.
    - At the end, if FIFO not empty: pop and enter START directly (zero gap).
    - Otherwise go to IDLE.
- Baud counter counts 0..DIV-1 within each bit and reloads to 0 on every bit transition.
- Latency: a write accepted at edge n into an empty FIFO with IDLE FSM makes uart_txd fall at edge n+2.
- busy=1 from the pop edge until the edge that returns the FSM to IDLE.
- Frame length without parity: (1 + DATA_BITS + STOP_BITS) * DIV cycles, exact.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - Adds parameter PARITY_ODD (default 0).
  - PARITY state inserted after DATA, lasting DIV cycles.
  - uart_txd = XOR of data bits, inverted when PARITY_ODD=1.
  - Frame grows by DIV cycles.
- Undefined: no PARITY state, no PARITY_ODD parameter; frames exactly as above.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding constants: IDLE, START, DATA, PARITY, STOP.
  - Divisor helper function computing DIV from clk_freq and uart_baud_rate.
- One sub-module, sync_fifo: parametrised width/depth with full, empty, level and overflow; reused later by the RX side.
- The FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
- Config clk_freq=16, uart_baud_rate=1 (DIV=16), 8N1; write 0x55 -> uart_txd: low 16 cycles, then 1,0,1,0,1,0,1,0 each 16 cycles, then high 16; frame = 160 cycles; fall at write edge +2.
- Write 0xA3, 0x0F, 0xFF on consecutive cycles -> three frames back-to-back, stop of frame k followed immediately by start of k+1, no gap; empty=1 after third pop, busy=0 after 480 cycles.
- FIFO_DEPTH=4: write 6 words while FSM idle -> first pops immediately, 4 stored, full=1, 6th write dropped, overflow pulses exactly once, level=4.
- Assert rst for one edge in the middle of the DATA bit 3 of 0x55 with 2 words queued -> next cycle uart_txd=1, level=0, empty=1, busy=0; no further frames.
- STOP_BITS=2, DATA_BITS=7, write 0x41 -> stop high for 32 cycles; frame = 160 cycles.
- With UART_TX_PARITY_EN, PARITY_ODD=0, write 0x07 -> parity bit = 1 after the 8 data bits; with PARITY_ODD=1 -> 0; frame = 176 cycles.
